// File: rtl/calculator_pkg.sv
// Shared calculator types and widths: adder width, memory word width, and the
// result_buffer state and queue-entry types.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  typedef enum logic {
    RB_LOWER = 1'b0,
    RB_UPPER = 1'b1
  } rb_state_t;

  typedef struct packed {
    logic                     ovf;
    logic [MEM_WORD_SIZE-1:0] word;
  } result_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Completed-word queue for result_buffer. The caller only asserts push_i when
// there is room (or a pop is accepted in the same cycle); pops while empty are ignored.
module result_fifo
  import calculator_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  result_entry_t push_data_i,
  input  logic          pop_i,
  output result_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  result_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign w_pop   = pop_i & ~empty_o;
  assign count_o = r_count;
  // Head is forced to zero when empty so stale entries never leak out.
  assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push_i, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/result_buffer.sv
// Pairs lower/upper adder results into one memory word and queues them for write-back.
// Optional CALC_CARRY_CHAIN_EN chains the lower-half carry into the upper-half add.
module result_buffer
  import calculator_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             load_i,
  input  logic                             loc_sel_i,
  input  logic [DATA_W-1:0]                sum_i,
  input  logic                             carry_out_i,
  output logic                             carry_in_o,
  output logic [MEM_WORD_SIZE-1:0]         buff_result_o,
  output logic                             buff_valid_o,
  input  logic                             buff_pop_i,
  output logic                             overflow_o,
  output logic                             full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  output logic                             drop_o,
  output logic                             seq_err_o,
  output logic                             dbg_state_o
);

  // Handshake: a word is consumed on any rising edge where buff_valid_o and
  // buff_pop_i are both high; buff_result_o is only meaningful while buff_valid_o.

  rb_state_t           r_state;
  logic [DATA_W-1:0]   r_lower;
  logic                r_drop;
  logic                r_seq_err;

  logic                w_push_req;
  logic                w_push;
  logic                w_drop;
  logic                w_pop_acc;
  logic                w_seq_err_set;
  logic                w_full;
  logic                w_empty;
  result_entry_t       w_push_data;
  result_entry_t       w_head;

  always_comb begin
    w_push_req    = 1'b0;
    w_seq_err_set = 1'b0;
    w_push_data   = '0;
    if (load_i) begin
      case (r_state)
        RB_LOWER: if (loc_sel_i) begin
          // Upper half with no lower half held: emit it with a zero lower half.
          w_push_req       = 1'b1;
          w_seq_err_set    = 1'b1;
          w_push_data.ovf  = carry_out_i;
          w_push_data.word = {sum_i, {DATA_W{1'b0}}};
        end
        RB_UPPER: if (loc_sel_i) begin
          w_push_req       = 1'b1;
          w_push_data.ovf  = carry_out_i;
          w_push_data.word = {sum_i, r_lower};
        end else begin
          w_seq_err_set    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_pop_acc = buff_pop_i & ~w_empty;
  assign w_push    = w_push_req & (~w_full | w_pop_acc) & ~clear_i;
  assign w_drop    = w_push_req & w_full & ~w_pop_acc;

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (buff_pop_i),
    .head_o      (w_head),
    .count_o     (count_o),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= RB_LOWER;
      r_lower   <= '0;
      r_drop    <= 1'b0;
      r_seq_err <= 1'b0;
    end else if (clear_i) begin
      r_state   <= RB_LOWER;
      r_lower   <= '0;
      r_drop    <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_seq_err_set) r_seq_err <= 1'b1;
      if (load_i) begin
        case (r_state)
          RB_LOWER: if (!loc_sel_i) begin
            r_lower <= sum_i;
            r_state <= RB_UPPER;
          end
          RB_UPPER: if (loc_sel_i) r_state <= RB_LOWER;
                    else           r_lower <= sum_i;
          default:  r_state <= RB_LOWER;
        endcase
      end
    end
  end

`ifdef CALC_CARRY_CHAIN_EN
  logic r_carry;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_carry <= 1'b0;
    end else if (clear_i) begin
      r_carry <= 1'b0;
    end else if (load_i) begin
      if (!loc_sel_i)                  r_carry <= carry_out_i;
      else if (r_state == RB_UPPER)    r_carry <= 1'b0;
    end
  end

  assign carry_in_o = (r_state == RB_UPPER) & r_carry;
`else
  assign carry_in_o = 1'b0;
`endif

  assign buff_result_o = w_head.word;
  assign overflow_o    = w_head.ovf;
  assign buff_valid_o  = ~w_empty;
  assign full_o        = w_full;
  assign drop_o        = r_drop;
  assign seq_err_o     = r_seq_err;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: directed scenarios with a queue scoreboard
// of {ovf, word} entries checked as the controller side pops them.
module tb_result_buffer;

  localparam int DW    = 32;
  localparam int MW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef CALC_CARRY_CHAIN_EN
  localparam logic CHAIN_EN = 1'b1;
`else
  localparam logic CHAIN_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          load_i = 1'b0;
  logic          loc_sel_i = 1'b0;
  logic [DW-1:0] sum_i = '0;
  logic          carry_out_i = 1'b0;
  logic          buff_pop_i = 1'b0;
  logic          carry_in_o;
  logic [MW-1:0] buff_result_o;
  logic          buff_valid_o;
  logic          overflow_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          drop_o;
  logic          seq_err_o;
  logic          dbg_state_o;

  logic [MW:0]   exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;

  result_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .load_i        (load_i),
    .loc_sel_i     (loc_sel_i),
    .sum_i         (sum_i),
    .carry_out_i   (carry_out_i),
    .carry_in_o    (carry_in_o),
    .buff_result_o (buff_result_o),
    .buff_valid_o  (buff_valid_o),
    .buff_pop_i    (buff_pop_i),
    .overflow_o    (overflow_o),
    .full_o        (full_o),
    .count_o       (count_o),
    .drop_o        (drop_o),
    .seq_err_o     (seq_err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // driver: inputs change on the falling edge, hold across one rising edge,
  // and the task returns at the next falling edge where outputs are sampled
  task automatic drive_load(input logic sel, input logic [DW-1:0] sum,
                            input logic cout, input logic pop);
    load_i = 1'b1; loc_sel_i = sel; sum_i = sum; carry_out_i = cout; buff_pop_i = pop;
    @(negedge clk_i);
    load_i = 1'b0; loc_sel_i = 1'b0; sum_i = '0; carry_out_i = 1'b0; buff_pop_i = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] lo, input logic [DW-1:0] hi, input logic cout);
    drive_load(1'b0, lo, 1'($urandom_range(0, 1)), 1'b0);
    drive_load(1'b1, hi, cout, 1'b0);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  // scoreboard drain: pop every queued word and compare against exp_q
  task automatic drain_and_check(input string name);
    logic [MW:0] exp;
    for (int i = 0; i < 2 * DEPTH && buff_valid_o; i++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s head: got %h, expected queue empty", name, {overflow_o, buff_result_o});
      end else begin
        exp = exp_q.pop_front();
        if ({overflow_o, buff_result_o} !== exp) begin
          miscompares++;
          $display("FAIL %s head: got %h, expected %h", name, {overflow_o, buff_result_o}, exp);
        end
      end
      buff_pop_i = 1'b1;
      @(negedge clk_i);
      buff_pop_i = 1'b0;
    end
    vectors++;
    if (buff_valid_o !== 1'b0 || count_o !== '0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain end: valid=%b count=%0d left=%0d, expected 0/0/0",
               name, buff_valid_o, count_o, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({carry_in_o, buff_result_o, buff_valid_o, overflow_o, full_o, count_o, drop_o,
         seq_err_o, dbg_state_o} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: valid=%b count=%0d result=%h seq=%b, expected all 0",
               buff_valid_o, count_o, buff_result_o, seq_err_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_carry_chain();
    drive_load(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    vectors++;
    if (carry_in_o !== CHAIN_EN || buff_valid_o !== 1'b0 || dbg_state_o !== 1'b1) begin
      miscompares++;
      $display("FAIL carry_in after lower: carry=%b valid=%b state=%b, expected %b/0/1",
               carry_in_o, buff_valid_o, dbg_state_o, CHAIN_EN);
    end
    drive_load(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 64'h0000_0001_FFFF_FFFF});
    vectors++;
    if (buff_result_o !== 64'h0000_0001_FFFF_FFFF || overflow_o !== 1'b0 ||
        count_o !== CW'(1) || carry_in_o !== 1'b0) begin
      miscompares++;
      $display("FAIL carry word: result=%h ovf=%b count=%0d carry=%b, expected 00000001ffffffff/0/1/0",
               buff_result_o, overflow_o, count_o, carry_in_o);
    end
    drain_and_check("carry");
  endtask

  task automatic test_overflow();
    logic [DW-1:0] lo, hi;
    lo = $urandom; hi = $urandom;
    push_word(lo, hi, 1'b1);
    exp_q.push_back({1'b1, hi, lo});
    vectors++;
    if (overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: got %b, expected 1", overflow_o);
    end
    drain_and_check("overflow");
  endtask

  task automatic test_full_drop();
    logic [DW-1:0] lo, hi;
    logic          c;
    logic [MW:0]   first;
    for (int w = 0; w < 5; w++) begin
      lo = $urandom; hi = $urandom; c = 1'($urandom_range(0, 1));
      push_word(lo, hi, c);
      if (w < 4) exp_q.push_back({c, hi, lo});
      if (w == 0) first = {c, hi, lo};
      if (w == 3) begin
        vectors++;
        if (full_o !== 1'b1 || count_o !== CW'(4) || drop_o !== 1'b0) begin
          miscompares++;
          $display("FAIL full after 4th: full=%b count=%0d drop=%b, expected 1/4/0",
                   full_o, count_o, drop_o);
        end
      end
    end
    vectors++;
    if (drop_o !== 1'b1 || count_o !== CW'(4) || {overflow_o, buff_result_o} !== first) begin
      miscompares++;
      $display("FAIL drop on 5th: drop=%b count=%0d head=%h, expected 1/4/%h",
               drop_o, count_o, {overflow_o, buff_result_o}, first);
    end
    @(negedge clk_i);
    vectors++;
    if (drop_o !== 1'b0 || dbg_state_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drop pulse width: drop=%b state=%b, expected 0/0", drop_o, dbg_state_o);
    end
  endtask

  // queue is left full by test_full_drop
  task automatic test_push_pop_full();
    logic [DW-1:0] lo, hi;
    logic          c;
    lo = $urandom; hi = $urandom; c = 1'($urandom_range(0, 1));
    drive_load(1'b0, lo, 1'b0, 1'b0);
    vectors++;
    if ({overflow_o, buff_result_o} !== exp_q[0]) begin
      miscompares++;
      $display("FAIL full head before pop: got %h, expected %h", {overflow_o, buff_result_o}, exp_q[0]);
    end
    void'(exp_q.pop_front());
    drive_load(1'b1, hi, c, 1'b1);
    exp_q.push_back({c, hi, lo});
    vectors++;
    if (drop_o !== 1'b0 || count_o !== CW'(4) || full_o !== 1'b1 ||
        {overflow_o, buff_result_o} !== exp_q[0]) begin
      miscompares++;
      $display("FAIL push+pop full: drop=%b count=%0d full=%b head=%h, expected 0/4/1/%h",
               drop_o, count_o, full_o, {overflow_o, buff_result_o}, exp_q[0]);
    end
    drain_and_check("push_pop_full");
  endtask

  task automatic test_seq_err();
    logic [DW-1:0] s1, s2, a, b, h;
    logic          c1, c2, cb;
    s1 = $urandom; s2 = $urandom; a = $urandom; b = $urandom; h = $urandom;
    c1 = 1'($urandom_range(0, 1)); c2 = 1'($urandom_range(0, 1)); cb = 1'($urandom_range(0, 1));
    drive_load(1'b1, s1, c1, 1'b0);
    exp_q.push_back({c1, s1, 32'h0});
    vectors++;
    if (seq_err_o !== 1'b1 || count_o !== CW'(1)) begin
      miscompares++;
      $display("FAIL seq upper-first: seq=%b count=%0d, expected 1/1", seq_err_o, count_o);
    end
    drive_load(1'b1, s2, c2, 1'b0);
    exp_q.push_back({c2, s2, 32'h0});
    // lower twice: second lower overwrites the first
    drive_load(1'b0, a, 1'b0, 1'b0);
    drive_load(1'b0, b, cb, 1'b0);
    vectors++;
    if (carry_in_o !== (CHAIN_EN & cb) || dbg_state_o !== 1'b1) begin
      miscompares++;
      $display("FAIL lower overwrite carry: carry=%b state=%b, expected %b/1",
               carry_in_o, dbg_state_o, CHAIN_EN & cb);
    end
    drive_load(1'b1, h, 1'b0, 1'b0);
    exp_q.push_back({1'b0, h, b});
    drain_and_check("seq_err");
    vectors++;
    if (seq_err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL seq sticky: got %b, expected 1", seq_err_o);
    end
    push_word($urandom, $urandom, 1'b0);
    pulse_clear();
    vectors++;
    if (count_o !== '0 || buff_valid_o !== 1'b0 || seq_err_o !== 1'b0 || buff_result_o !== '0) begin
      miscompares++;
      $display("FAIL clear: count=%0d valid=%b seq=%b result=%h, expected 0/0/0/0",
               count_o, buff_valid_o, seq_err_o, buff_result_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] h;
    h = $urandom;
    push_word($urandom, $urandom, 1'b1);
    drive_load(1'b0, $urandom, 1'b1, 1'b0);
    vectors++;
    if (carry_in_o !== CHAIN_EN || buff_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre-reset: carry=%b valid=%b, expected %b/1", carry_in_o, buff_valid_o, CHAIN_EN);
    end
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if ({carry_in_o, buff_result_o, buff_valid_o, overflow_o, full_o, count_o, drop_o,
         seq_err_o, dbg_state_o} !== '0) begin
      miscompares++;
      $display("FAIL async reset: valid=%b count=%0d result=%h carry=%b, expected all 0",
               buff_valid_o, count_o, buff_result_o, carry_in_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_load(1'b1, h, 1'b0, 1'b0);
    exp_q.push_back({1'b0, h, 32'h0});
    vectors++;
    if (seq_err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL upper after reset: seq=%b, expected 1", seq_err_o);
    end
    drain_and_check("reset_mid");
    pulse_clear();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] lo, hi;
    logic          c;
    // push into an empty queue with pop held: no bypass, count becomes 1
    lo = $urandom; hi = $urandom;
    drive_load(1'b0, lo, 1'b0, 1'b0);
    drive_load(1'b1, hi, 1'b1, 1'b1);
    exp_q.push_back({1'b1, hi, lo});
    vectors++;
    if (count_o !== CW'(1)) begin
      miscompares++;
      $display("FAIL push into empty with pop: count=%0d, expected 1", count_o);
    end
    for (int w = 0; w < 3; w++) begin
      lo = $urandom; hi = $urandom; c = 1'($urandom_range(0, 1));
      push_word(lo, hi, c);
      exp_q.push_back({c, hi, lo});
    end
    vectors++;
    if (count_o !== CW'(4) || full_o !== 1'b1 || seq_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back fill: count=%0d full=%b seq=%b, expected 4/1/0",
               count_o, full_o, seq_err_o);
    end
    drain_and_check("back_to_back");
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_full_drop();
    test_push_pop_full();
    test_seq_err();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
